// File: rtl/ir_motion_controller_pkg.sv
// ir_pkg: shared types and constants for the IR motion controller.
//   dir_t      : motion direction encoding (matches the `direction` output)
//   sc_t       : legacy 3-bit state_control code consumed by json_to_uart_top
//   CMD_*      : NEC command codes that the controller acts on
//   *_MSB/LSB  : bit positions of the fields inside a 32-bit NEC frame
//   legacy_code: maps direction + speed extremes onto the legacy code
package ir_pkg;

    typedef enum logic [1:0] {
        DIR_STOP  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_FWD   = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        SC_STOP   = 3'b000,
        SC_LEFT   = 3'b001,
        SC_RIGHT  = 3'b010,
        SC_FAST   = 3'b011,
        SC_MEDIUM = 3'b100,
        SC_SLOW   = 3'b110
    } sc_t;

    localparam logic [7:0] CMD_STOP   = 8'h0C;
    localparam logic [7:0] CMD_LEFT   = 8'h14;
    localparam logic [7:0] CMD_RIGHT  = 8'h18;
    localparam logic [7:0] CMD_FWD    = 8'h16;
    localparam logic [7:0] CMD_SPD_UP = 8'h1B;
    localparam logic [7:0] CMD_SPD_DN = 8'h1F;

    localparam int ADDR_MSB  = 31;
    localparam int ADDR_LSB  = 24;
    localparam int CMD_MSB   = 23;
    localparam int CMD_LSB   = 16;
    localparam int INV_MSB   = 15;
    localparam int INV_LSB   = 8;
    localparam int IADDR_MSB = 7;
    localparam int IADDR_LSB = 0;

    // FORWARD is split into three legacy speed bands; the other directions
    // map one-to-one.
    function automatic sc_t legacy_code(dir_t dir, logic spd_max, logic spd_zero);
        sc_t code;
        case (dir)
            DIR_LEFT:  code = SC_LEFT;
            DIR_RIGHT: code = SC_RIGHT;
            DIR_FWD: begin
                if (spd_max)       code = SC_FAST;
                else if (spd_zero) code = SC_SLOW;
                else               code = SC_MEDIUM;
            end
            default:   code = SC_STOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ir_motion_controller_if.sv
// ir_motion_controller_if: IR receiver strobes in, motion state out.
//   master: drives ir_data/data_ready/repeat_pulse, observes the results
//   slave : the controller
// Handshake: data_ready and repeat_pulse are one-cycle strobes with no
// ready/back-pressure; every strobe is consumed on the clock edge it is
// high, and ir_data is only meaningful while data_ready = 1.
interface ir_motion_controller_if #(
    parameter int SPEED_LEVELS = 4
);
    logic [31:0]                     ir_data;
    logic                            data_ready;
    logic                            repeat_pulse;
    logic [1:0]                      direction;
    logic [$clog2(SPEED_LEVELS)-1:0] speed;
    logic [2:0]                      state_control;
    logic                            cmd_valid;
    logic                            frame_error;
    logic                            timeout;
    logic                            toggle;

    modport master (
        output ir_data, data_ready, repeat_pulse,
        input  direction, speed, state_control, cmd_valid, frame_error, timeout, toggle
    );

    modport slave (
        input  ir_data, data_ready, repeat_pulse,
        output direction, speed, state_control, cmd_valid, frame_error, timeout, toggle
    );
endinterface

// File: rtl/ir_motion_controller_deadman_timer.sv
// ir_deadman_timer: reload/decrement/expire counter.
//   clk, rst : clock, asynchronous active-high reset
//   reload   : load TIMEOUT_CYCLES (takes priority over expiry)
//   run      : decrement enable (motion active)
//   expire   : high in the cycle whose edge takes the count from 1 to 0
// TIMEOUT_CYCLES = 0 leaves the count at 0 so expire never fires.
module ir_deadman_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic run,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    // A reload in the same cycle suppresses expiry.
    assign expire = run && !reload && (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= LOAD;
        end else if (run && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/ir_motion_controller.sv
// ir_motion_controller: validates NEC frames / repeat codes and keeps a
// motion direction plus a saturating speed level, with a dead-man stop.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ir_motion_controller_if.slave (strobes in, registered state out)
module ir_motion_controller
    import ir_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int          SPEED_LEVELS   = 4,
    parameter int          SPEED_INIT     = 1,
    parameter bit          ADDR_FILTER_EN = 1'b1,
    parameter logic [7:0]  REMOTE_ADDR    = 8'h00,
    parameter bit          CHECK_INVERSE  = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    ir_motion_controller_if.slave bus
);
    localparam int SPD_W = $clog2(SPEED_LEVELS);
    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(SPEED_LEVELS - 1);
    localparam logic [SPD_W-1:0] SPD_RST = SPD_W'(SPEED_INIT);

    dir_t             dir_q, dir_n;
    logic [SPD_W-1:0] spd_q, spd_n;
    sc_t              sc_q;
    logic [7:0]       last_cmd;
    logic             rpt_armed;
    logic             cmd_valid_q, frame_error_q, timeout_q, toggle_q;

    logic [7:0] f_addr, f_cmd, f_inv, step_cmd;
    logic       addr_ok, inv_ok, accept, rpt_hit, expire;

    assign f_addr = bus.ir_data[ADDR_MSB:ADDR_LSB];
    assign f_cmd  = bus.ir_data[CMD_MSB:CMD_LSB];
    assign f_inv  = bus.ir_data[INV_MSB:INV_LSB];

    assign addr_ok = !ADDR_FILTER_EN || (f_addr == REMOTE_ADDR);
    assign inv_ok  = !CHECK_INVERSE  || (f_inv == ~f_cmd);
    assign accept  = bus.data_ready && addr_ok && inv_ok;
    // A repeat arriving alongside any frame (good or bad) is dropped.
    assign rpt_hit = bus.repeat_pulse && !bus.data_ready && rpt_armed;

    ir_deadman_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .reload (accept || rpt_hit),
        .run    (dir_q != DIR_STOP),
        .expire (expire)
    );

    always_comb begin
        dir_n    = dir_q;
        spd_n    = spd_q;
        step_cmd = 8'h00;
        if (accept) begin
            case (f_cmd)
                CMD_STOP:  dir_n = DIR_STOP;
                CMD_LEFT:  dir_n = DIR_LEFT;
                CMD_RIGHT: dir_n = DIR_RIGHT;
                CMD_FWD:   dir_n = DIR_FWD;
                default:   dir_n = dir_q;
            endcase
            step_cmd = f_cmd;
        end else if (rpt_hit) begin
            // Only speed steps are auto-repeated; direction is already set.
            step_cmd = last_cmd;
        end
        if (step_cmd == CMD_SPD_UP && spd_q != SPD_MAX) begin
            spd_n = spd_q + SPD_W'(1);
        end else if (step_cmd == CMD_SPD_DN && spd_q != '0) begin
            spd_n = spd_q - SPD_W'(1);
        end
        // expire is already masked by any reload, so a frame always wins.
        if (expire) begin
            dir_n = DIR_STOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q         <= DIR_STOP;
            spd_q         <= SPD_RST;
            sc_q          <= SC_STOP;
            last_cmd      <= CMD_STOP;
            rpt_armed     <= 1'b0;
            cmd_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            timeout_q     <= 1'b0;
            toggle_q      <= 1'b0;
        end else begin
            dir_q         <= dir_n;
            spd_q         <= spd_n;
            sc_q          <= legacy_code(dir_n, spd_n == SPD_MAX, spd_n == '0);
            cmd_valid_q   <= accept;
            frame_error_q <= bus.data_ready && !accept;
            timeout_q     <= expire;
            if (accept) begin
                toggle_q  <= ~toggle_q;
                last_cmd  <= f_cmd;
                rpt_armed <= 1'b1;
            end else if (expire) begin
                rpt_armed <= 1'b0;
            end
        end
    end

    assign bus.direction     = dir_q;
    assign bus.speed         = spd_q;
    assign bus.state_control = sc_q;
    assign bus.cmd_valid     = cmd_valid_q;
    assign bus.frame_error   = frame_error_q;
    assign bus.timeout       = timeout_q;
    assign bus.toggle        = toggle_q;
endmodule

// File: tb/tb_ir_motion_controller.sv
// Directed bench for ir_motion_controller (TIMEOUT_CYCLES = 100).
module tb_ir_motion_controller;

    localparam int TMO = 100;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   lat;

    ir_motion_controller_if #(.SPEED_LEVELS(4)) bus ();

    ir_motion_controller #(
        .TIMEOUT_CYCLES(TMO),
        .SPEED_LEVELS  (4),
        .SPEED_INIT    (1),
        .ADDR_FILTER_EN(1'b1),
        .REMOTE_ADDR   (8'h00),
        .CHECK_INVERSE (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers (called at a negedge, return at a negedge) ----------------
    task automatic send_frame(input logic [31:0] d);
        bus.ir_data    = d;
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        bus.ir_data    = 32'h0;
    endtask

    task automatic send_repeat();
        bus.repeat_pulse = 1'b1;
        @(negedge clk);
        bus.repeat_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Cycles until timeout pulses, bounded; returns 999 if it never does.
    task automatic wait_timeout(output int n);
        n = 999;
        for (int i = 1; i <= 2 * TMO; i++) begin
            @(negedge clk);
            if (bus.timeout) begin
                n = i;
                break;
            end
        end
    endtask

    localparam logic [31:0] F_FWD   = 32'h0016E9FF;
    localparam logic [31:0] F_UP    = 32'h001BE4FF;
    localparam logic [31:0] F_DN    = 32'h001FE0FF;
    localparam logic [31:0] F_LEFT  = 32'h0014EBFF;
    localparam logic [31:0] F_RIGHT = 32'h0018E7FF;
    localparam logic [31:0] F_STOP  = 32'h000CF3FF;
    localparam logic [31:0] F_UNK   = 32'h0042BDFF;
    localparam logic [31:0] F_BADI  = 32'h001400FF;
    localparam logic [31:0] F_BADA  = 32'h0514EBFA;

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        rst              = 1'b1;
        bus.ir_data      = 32'h0;
        bus.data_ready   = 1'b0;
        bus.repeat_pulse = 1'b0;
        idle(3);

        // reset state
        check("rst_dir", 32'(bus.direction), 32'h0);
        check("rst_speed", 32'(bus.speed), 32'h1);
        check("rst_sc", 32'(bus.state_control), 32'h0);
        check("rst_toggle", 32'(bus.toggle), 32'h0);
        check("rst_pulses", {29'h0, bus.cmd_valid, bus.frame_error, bus.timeout}, 32'h0);
        rst = 1'b0;
        idle(2);

        // first accepted frame: FORWARD
        send_frame(F_FWD);
        check("fwd_dir", 32'(bus.direction), 32'h3);
        check("fwd_speed", 32'(bus.speed), 32'h1);
        check("fwd_sc", 32'(bus.state_control), 32'h4);
        check("fwd_valid", 32'(bus.cmd_valid), 32'h1);
        check("fwd_toggle", 32'(bus.toggle), 32'h1);
        idle(1);
        check("valid_pulse_end", 32'(bus.cmd_valid), 32'h0);

        // speed up x3 saturates at 3, repeats stay saturated
        send_frame(F_UP);
        check("up1_speed", 32'(bus.speed), 32'h2);
        send_frame(F_UP);
        check("up2_speed", 32'(bus.speed), 32'h3);
        send_frame(F_UP);
        check("up3_speed", 32'(bus.speed), 32'h3);
        send_repeat();
        send_repeat();
        check("rpt_sat_speed", 32'(bus.speed), 32'h3);
        check("rpt_sat_sc", 32'(bus.state_control), 32'h3);
        check("rpt_sat_dir", 32'(bus.direction), 32'h3);

        // speed down x4 saturates at 0
        send_frame(F_DN);
        check("dn1_speed", 32'(bus.speed), 32'h2);
        send_frame(F_DN);
        send_frame(F_DN);
        send_frame(F_DN);
        check("dn4_speed", 32'(bus.speed), 32'h0);
        check("dn4_sc", 32'(bus.state_control), 32'h6);

        // a repeat re-applies the last speed step
        send_frame(F_UP);
        check("up_after_dn_sc", 32'(bus.state_control), 32'h4);
        send_repeat();
        check("rpt_step_speed", 32'(bus.speed), 32'h2);
        // 9 accepted frames so far
        check("toggle_parity", 32'(bus.toggle), 32'h1);

        // rejected frames
        send_frame(F_BADI);
        check("badinv_err", 32'(bus.frame_error), 32'h1);
        check("badinv_valid", 32'(bus.cmd_valid), 32'h0);
        check("badinv_dir", 32'(bus.direction), 32'h3);
        send_frame(F_BADA);
        check("badaddr_err", 32'(bus.frame_error), 32'h1);
        check("badaddr_dir", 32'(bus.direction), 32'h3);
        check("badaddr_toggle", 32'(bus.toggle), 32'h1);

        // STOP keeps speed
        send_frame(F_STOP);
        check("stop_dir", 32'(bus.direction), 32'h0);
        check("stop_sc", 32'(bus.state_control), 32'h0);
        check("stop_speed", 32'(bus.speed), 32'h2);

        // LEFT, unknown code, speed down, then silence -> timeout
        send_frame(F_LEFT);
        check("left_sc", 32'(bus.state_control), 32'h1);
        send_frame(F_UNK);
        check("unk_valid", 32'(bus.cmd_valid), 32'h1);
        check("unk_dir", 32'(bus.direction), 32'h1);
        send_frame(F_DN);
        check("left_dn_speed", 32'(bus.speed), 32'h1);
        wait_timeout(lat);
        check("tmo_latency", 32'(lat), 32'(TMO));
        check("tmo_dir", 32'(bus.direction), 32'h0);
        idle(1);
        check("tmo_pulse_end", 32'(bus.timeout), 32'h0);
        // disarmed: repeat of SPD_DN must not step speed
        send_repeat();
        check("disarmed_rpt_speed", 32'(bus.speed), 32'h1);
        check("disarmed_rpt_dir", 32'(bus.direction), 32'h0);
        idle(5);
        check("stop_no_tmo", 32'(bus.timeout), 32'h0);

        // frame + repeat on the expiry cycle: frame wins, repeat dropped
        send_frame(F_LEFT);
        send_frame(F_UP);
        check("pre_race_speed", 32'(bus.speed), 32'h2);
        idle(TMO - 1);
        check("pre_race_no_tmo", 32'(bus.timeout), 32'h0);
        bus.repeat_pulse = 1'b1;
        send_frame(F_RIGHT);
        bus.repeat_pulse = 1'b0;
        check("race_dir", 32'(bus.direction), 32'h2);
        check("race_tmo", 32'(bus.timeout), 32'h0);
        check("race_speed", 32'(bus.speed), 32'h2);
        check("race_valid", 32'(bus.cmd_valid), 32'h1);
        wait_timeout(lat);
        check("race_reload_latency", 32'(lat), 32'(TMO));

        // asynchronous reset mid-stream
        send_frame(F_FWD);
        check("fwd2_sc", 32'(bus.state_control), 32'h4);
        #2 rst = 1'b1;
        #1;
        check("arst_dir", 32'(bus.direction), 32'h0);
        check("arst_speed", 32'(bus.speed), 32'h1);
        check("arst_sc", 32'(bus.state_control), 32'h0);
        check("arst_toggle", 32'(bus.toggle), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        send_repeat();
        check("post_rst_rpt_dir", 32'(bus.direction), 32'h0);
        check("post_rst_rpt_speed", 32'(bus.speed), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ir_motion_controller.md
# ir_motion_controller

Parametrised IR command decoder for the robot's remote-control path. It takes 32-bit NEC frames and repeat pulses from the IR receiver, validates them, and maintains a motion direction plus a saturating speed level. A dead-man timer forces STOP when the remote goes silent. It also drives the legacy 3-bit `state_control` code consumed by `json_to_uart_top`, so it is a drop-in replacement for the existing controller.

## Interface
- `TIMEOUT_CYCLES`, default 5_000_000: cycles without an accepted frame or repeat before forced STOP (100 ms at 50 MHz); 0 disables the timer.
- `SPEED_LEVELS`, default 4: number of speed levels, minimum 2.
- `SPEED_INIT`, default 1: speed after reset; must be < `SPEED_LEVELS`.
- `ADDR_FILTER_EN`, default 1: when 1, frames whose address ≠ `REMOTE_ADDR` are rejected.
- `REMOTE_ADDR`, default 8'h00: accepted remote address.
- `CHECK_INVERSE`, default 1: when 1, require `ir_data[15:8] == ~ir_data[23:16]`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ir_data`  in  32  NEC frame: [31:24] address, [23:16] command, [15:8] inverted command, [7:0] inverted address; sampled only when `data_ready` = 1.
- `data_ready`  in  1  one-cycle strobe, new frame on `ir_data`.
- `repeat_pulse`  in  1  one-cycle strobe, NEC repeat code received.
- `direction`  out  2  00 STOP, 01 LEFT, 10 RIGHT, 11 FORWARD.
- `speed`  out  $clog2(SPEED_LEVELS)  current speed level.
- `state_control`  out  3  legacy code: STOP 000, LEFT 001, RIGHT 010, FAST 011, MEDIUM 100, SLOW 110.
- `cmd_valid`  out  1  one-cycle pulse per accepted frame.
- `frame_error`  out  1  one-cycle pulse per rejected frame.
- `timeout`  out  1  one-cycle pulse when the dead-man timer forces STOP.
- `toggle`  out  1  inverts on every accepted frame.

## Operation
- Frame acceptance: `data_ready` = 1, and address passes the filter (if enabled), and inverse check passes (if enabled). A failing frame pulses `frame_error` and changes no other state.
- Command codes for accepted frames:
  - 0x0C sets STOP.
  - 0x14 sets LEFT.
  - 0x18 sets RIGHT.
  - 0x16 sets FORWARD.
  - 0x1B increments speed, saturating at `SPEED_LEVELS`-1.
  - 0x1F decrements speed, saturating at 0.
  - Any other code: `cmd_valid` still pulses, but direction and speed are unchanged. This replaces the old default-to-STOP behaviour.
- Speed commands do not change direction. Speed is retained across STOP and timeout.
- Repeat handling:
  - `last_cmd` holds the most recent accepted command code, and `rpt_armed` says whether repeats are honoured.
  - `repeat_pulse` while `rpt_armed` = 1 reloads the timer.
  - If `last_cmd` is 0x1B or 0x1F, the repeat also re-applies the speed step.
  - Any accepted frame sets `rpt_armed`; reset and timeout clear it. Repeats while disarmed are ignored.
- Dead-man timer:
  - Reloads to `TIMEOUT_CYCLES` on every accepted frame or honoured repeat.
  - Decrements while `direction` ≠ STOP.
  - On reaching 0: direction becomes STOP, `timeout` pulses, `rpt_armed` clears.
  - Does not run, and never pulses, while `direction` = STOP.
- `state_control` mapping:
  - STOP, LEFT and RIGHT map directly.
  - FORWARD maps to FAST if speed = `SPEED_LEVELS`-1, SLOW if speed = 0, otherwise MEDIUM.
- Reset values: direction STOP, speed `SPEED_INIT`, `state_control` 000, `toggle` 0, all pulses 0, timer 0, `rpt_armed` 0, `last_cmd` 0x0C.

## Timing
- All outputs are registered. Latency is 1 cycle from the strobe edge to the updated outputs and pulses.
- `data_ready` and `repeat_pulse` in the same cycle: the frame is processed and the repeat is dropped.
- Timer expiry and an accepted frame in the same cycle: the frame wins, the timer reloads, and `timeout` does not pulse.
- Back-to-back strobes on consecutive cycles are each processed. No input buffering is required.
- Reset asserted mid-operation returns everything to reset values immediately, asynchronously.
- Timer counter width is $clog2(`TIMEOUT_CYCLES`+1).

## Structure
- Package `ir_pkg`:
  - `dir_t` enum.
  - Legacy `state_control` enum.
  - NEC command code constants (`CMD_STOP`, `CMD_LEFT`, `CMD_RIGHT`, `CMD_FWD`, `CMD_SPD_UP`, `CMD_SPD_DN`).
  - Frame field index localparams.
- Sub-module `ir_deadman_timer`: reload/decrement/expire counter, parametrised by `TIMEOUT_CYCLES`.

## Test plan
- Reset, then an accepted frame 0x00_16_E9_FF → after 1 cycle direction 11, speed 1, `state_control` 100, `cmd_valid` and `toggle` = 1.
- From FORWARD, send 0x1B three times, then two `repeat_pulse` → speed saturates at 3 and `state_control` shows 011. Then send 0x1F four times → speed 0 and 110.
- Frame 0x00_14_00_FF (bad inverse) → `frame_error` pulses and direction is unchanged. Frame 0x05_14_EB_FA with `ADDR_FILTER_EN`=1 → rejected.
- `TIMEOUT_CYCLES`=100, send LEFT, then no input → `timeout` pulses at cycle 101, direction STOP. A subsequent `repeat_pulse` is ignored.
- `data_ready` (RIGHT) and `repeat_pulse` in the same cycle as timer expiry → direction RIGHT, no `timeout`, timer reloaded.
- Unknown code 0x42 while LEFT → `cmd_valid` pulses, direction stays LEFT. Assert `rst` mid-stream → all outputs return to reset values.
